boot_loader_ctrl: RTL and testbench
===================================

Name: boot_loader_ctrl

Overview:
Sequencer and arbiter that owns the boot memory after reset. It copies BOOT_WORDS words from the combinational-read boot memory into instruction memory, holding the core in reset while it copies. Once the copy completes, it releases the core and hands the shared instruction-memory request port to the core's fetch path as a pass-through. It sits between the boot memory, the IMEM request port and the core fetch unit.

Parameters:
BOOT_WORDS, 64, number of 32-bit words copied; minimum 1.
IMEM_BASE, 32'h0000_0000, byte address in IMEM of boot word 0.
IDX_W, $clog2(BOOT_WORDS) with a minimum of 1, width of the word index (derived; not overridden).

Ports:
clock  in  1  system clock
reset  in  1  reset, synchronous, active-high
bmem_addr  out  32  boot memory word index; zero-extended idx
bmem_data  in  32  boot memory read data; combinational from bmem_addr in the same cycle
imem_req_valid  out  1  IMEM request valid
imem_req_we  out  1  1 = write (boot copy), 0 = read (core fetch)
imem_req_addr  out  32  IMEM byte address
imem_req_wdata  out  32  IMEM write data
imem_req_ready  in  1  IMEM accepts the request when valid && ready
core_req_valid  in  1  core fetch request
core_req_addr  in  32  core fetch byte address
core_req_ready  out  1  core fetch accepted
core_hold  out  1  high = core held in reset / stalled
boot_done  out  1  high once the copy is complete
reboot_req  in  1  single-cycle pulse; repeats the copy

Behaviour:
- State register values: S_READ, S_WRITE, S_DONE. Registers: state, idx[IDX_W-1:0], data_q[31:0].
- Reset (synchronous), at the next edge:
  - state=S_READ, idx=0, data_q=0.
  - Resulting outputs: core_hold=1, boot_done=0, imem_req_valid=0, core_req_ready=0, bmem_addr=0.
- Reset mid-copy: abandons the copy, including any unaccepted write (valid drops next cycle). The copy restarts at word 0.
- S_READ:
  - bmem_addr=idx; data_q <= bmem_data; next state S_WRITE.
  - imem_req_valid=0.
- S_WRITE:
  - imem_req_valid=1, we=1, addr=IMEM_BASE + {idx,2'b00}, truncated to 32 bits, wdata=data_q.
  - If imem_req_ready=0: stay in S_WRITE; valid, addr and wdata stay stable.
  - If imem_req_ready=1 and idx==BOOT_WORDS-1: next state S_DONE.
  - If imem_req_ready=1 otherwise: idx <= idx+1; next state S_READ.
  - Minimum cost is 2 cycles per word. With ready held high, boot_done rises on cycle 2*BOOT_WORDS+1 after reset deasserts.
- S_DONE:
  - core_hold=0, boot_done=1, bmem_addr=0.
  - Combinational pass-through: imem_req_valid=core_req_valid, we=0, addr=core_req_addr, wdata=0, core_req_ready=imem_req_ready.
  - reboot_req=1: next state S_READ, idx=0. The core request in that same cycle still passes through. From the next cycle core_hold=1 and boot_done=0.
- In S_READ and S_WRITE: core_req_ready=0 and core requests are never forwarded, whatever the value of core_req_valid.
- reboot_req is ignored in S_READ and S_WRITE.
- Reset has priority over reboot_req.
- core_hold and boot_done are always complements of each other.
- No write is ever issued twice for one idx, and no idx is skipped.

Decomposition:
- Package boot_ctrl_pkg:
  - state enum (S_READ, S_WRITE, S_DONE);
  - default BOOT_WORDS and IMEM_BASE constants;
  - IMEM request field widths.
- One sub-module, imem_port_mux: a combinational 2:1 mux between the copy-engine request and the core request, selected by boot_done, with the ready routing. FSM, counter and data_q stay in the top module.

Test Plan:
1. BOOT_WORDS=4, ready tied 1, bmem_data=0x10+addr -> writes (addr,data) = (0x0,0x10), (0x4,0x11), (0x8,0x12), (0xC,0x13) on cycles 2,4,6,8 after reset; boot_done=1 and core_hold=0 at cycle 9; exactly 4 accepted writes.
2. Backpressure: ready=0 for 3 cycles while idx=1 -> valid=1, addr=0x4, wdata=0x11 stable for all 3 cycles; idx holds; a single write for word 1; boot_done delayed by 3 cycles.
3. Core pass-through: before done, core_req_valid=1 -> core_req_ready=0 and no IMEM read. After done, core_req_addr=0x40 -> imem_req_valid=1, we=0, addr=0x40 in the same cycle; core_req_ready follows imem_req_ready over a 1,0,1 pattern.
4. reboot_req pulse in S_DONE -> next cycle core_hold=1, boot_done=0, copy restarts at word 0 with 4 fresh writes. A reboot_req pulse during the copy has no effect.
5. reset asserted for 1 cycle while idx=2 in S_WRITE with ready=0 -> next cycle valid=0 and idx=0; the full 4-word copy repeats from addr 0x0.
6. IMEM_BASE=0x8000_0000, BOOT_WORDS=1 -> single write to 0x8000_0000; boot_done at cycle 3; bmem_addr=0 throughout.

Source files
------------

// File: rtl/boot_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// boot_ctrl_pkg
// Shared types and constants for the boot loader controller.
//   - boot_state_e   : copy-engine state encoding (S_READ, S_WRITE, S_DONE)
//   - BOOT_WORDS_DEF : default number of 32-bit words copied at boot
//   - IMEM_BASE_DEF  : default IMEM byte address of boot word 0
//   - ADDR_W/DATA_W  : IMEM request field widths
//   - word_byte_addr : word index -> IMEM byte address helper
// -----------------------------------------------------------------------------
package boot_ctrl_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   localparam int unsigned       BOOT_WORDS_DEF = 64;
   localparam logic [ADDR_W-1:0] IMEM_BASE_DEF  = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_READ  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } boot_state_e;

   // Byte address of a boot word; the sum wraps at 32 bits on purpose.
   function automatic logic [ADDR_W-1:0] word_byte_addr(
      input logic [ADDR_W-1:0] base,
      input logic [ADDR_W-1:0] word_idx
   );
      return base + {word_idx[ADDR_W-3:0], 2'b00};
   endfunction

endpackage

// File: rtl/imem_port_mux.sv
// -----------------------------------------------------------------------------
// imem_port_mux
// Combinational 2:1 arbiter for the shared IMEM request port. While sel_core
// is low the copy engine owns the port; once high, the core fetch request is
// passed straight through as a read and IMEM ready is routed back to the core.
// Ports:
//   sel_core                       : 1 = core owns the port (boot finished)
//   copy_valid/we/addr/wdata       : copy-engine request
//   copy_ready                     : IMEM ready as seen by the copy engine
//   core_valid/core_addr           : core fetch request
//   core_ready                     : IMEM ready as seen by the core
//   imem_valid/we/addr/wdata       : request driven to IMEM
//   imem_ready                     : IMEM acceptance
// -----------------------------------------------------------------------------
module imem_port_mux
   import boot_ctrl_pkg::*;
(
   input  logic              sel_core,
   input  logic              copy_valid,
   input  logic              copy_we,
   input  logic [ADDR_W-1:0] copy_addr,
   input  logic [DATA_W-1:0] copy_wdata,
   output logic              copy_ready,
   input  logic              core_valid,
   input  logic [ADDR_W-1:0] core_addr,
   output logic              core_ready,
   output logic              imem_valid,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   input  logic              imem_ready
);

   // Port ownership select and ready steering.
   always_comb begin
      imem_valid = 1'b0;
      imem_we    = 1'b0;
      imem_addr  = {ADDR_W{1'b0}};
      imem_wdata = {DATA_W{1'b0}};
      copy_ready = 1'b0;
      core_ready = 1'b0;
      if (sel_core) begin
         // Core fetches are always reads; write data is driven to zero.
         imem_valid = core_valid;
         imem_we    = 1'b0;
         imem_addr  = core_addr;
         imem_wdata = {DATA_W{1'b0}};
         core_ready = imem_ready;
         copy_ready = 1'b0;
      end else begin
         // Core requests are never forwarded while the copy owns the port.
         imem_valid = copy_valid;
         imem_we    = copy_we;
         imem_addr  = copy_addr;
         imem_wdata = copy_wdata;
         copy_ready = imem_ready;
         core_ready = 1'b0;
      end
   end

endmodule

// File: rtl/boot_loader_ctrl.sv
// -----------------------------------------------------------------------------
// boot_loader_ctrl
// Copies BOOT_WORDS words from a combinational-read boot memory into IMEM
// (one read cycle then one write cycle per word), holding the core in reset
// meanwhile. When the last write is accepted the core is released and the
// IMEM request port becomes a pass-through for core fetches. A reboot_req
// pulse in the finished state repeats the copy from word 0.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   bmem_addr / bmem_data   : boot memory word index / same-cycle read data
//   imem_req_*              : shared IMEM request port (valid/we/addr/wdata/ready)
//   core_req_valid/addr     : core fetch request; core_req_ready: accepted
//   core_hold               : core held in reset (complement of boot_done)
//   boot_done               : copy complete
//   reboot_req              : single-cycle pulse, honoured only when done
// -----------------------------------------------------------------------------
module boot_loader_ctrl
   import boot_ctrl_pkg::*;
#(
   parameter int unsigned       BOOT_WORDS = BOOT_WORDS_DEF,
   parameter logic [ADDR_W-1:0] IMEM_BASE  = IMEM_BASE_DEF
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] bmem_addr,
   input  logic [DATA_W-1:0] bmem_data,
   output logic              imem_req_valid,
   output logic              imem_req_we,
   output logic [ADDR_W-1:0] imem_req_addr,
   output logic [DATA_W-1:0] imem_req_wdata,
   input  logic              imem_req_ready,
   input  logic              core_req_valid,
   input  logic [ADDR_W-1:0] core_req_addr,
   output logic              core_req_ready,
   output logic              core_hold,
   output logic              boot_done,
   input  logic              reboot_req
);

   localparam int unsigned      IDX_W    = (BOOT_WORDS > 1) ? $clog2(BOOT_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BOOT_WORDS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);

   boot_state_e       state_r;
   boot_state_e       state_s;
   logic [IDX_W-1:0]  idx_r;
   logic [IDX_W-1:0]  idx_s;
   logic [DATA_W-1:0] data_q_r;
   logic [DATA_W-1:0] data_q_s;
   logic              boot_done_r;
   logic              core_hold_r;

   logic [ADDR_W-1:0] idx_ext_s;
   logic              copy_valid_s;
   logic [ADDR_W-1:0] copy_addr_s;
   logic [DATA_W-1:0] copy_wdata_s;
   logic              copy_ready_s;

   assign idx_ext_s = ADDR_W'(idx_r);

   // State, word index, captured read data and status flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= S_READ;
         idx_r       <= {IDX_W{1'b0}};
         data_q_r    <= {DATA_W{1'b0}};
         boot_done_r <= 1'b0;
         core_hold_r <= 1'b1;
      end else begin
         state_r     <= state_s;
         idx_r       <= idx_s;
         data_q_r    <= data_q_s;
         // Status flags are registered from the next state so they line up
         // with state_r and remain strict complements.
         boot_done_r <= (state_s == S_DONE);
         core_hold_r <= (state_s != S_DONE);
      end
   end

   // Copy sequencer: next state, index, data capture and copy request.
   always_comb begin
      state_s      = state_r;
      idx_s        = idx_r;
      data_q_s     = data_q_r;
      bmem_addr    = {ADDR_W{1'b0}};
      copy_valid_s = 1'b0;
      copy_addr_s  = {ADDR_W{1'b0}};
      copy_wdata_s = {DATA_W{1'b0}};
      case (state_r)
         S_READ: begin
            bmem_addr = idx_ext_s;
            data_q_s  = bmem_data;
            state_s   = S_WRITE;
         end
         S_WRITE: begin
            // Request stays stable until accepted; idx only advances on
            // acceptance so each word is written exactly once.
            bmem_addr    = idx_ext_s;
            copy_valid_s = 1'b1;
            copy_addr_s  = word_byte_addr(IMEM_BASE, idx_ext_s);
            copy_wdata_s = data_q_r;
            if (copy_ready_s) begin
               if (idx_r == LAST_IDX) begin
                  state_s = S_DONE;
               end else begin
                  idx_s   = idx_r + IDX_ONE;
                  state_s = S_READ;
               end
            end else begin
               state_s = S_WRITE;
            end
         end
         S_DONE: begin
            if (reboot_req) begin
               idx_s   = {IDX_W{1'b0}};
               state_s = S_READ;
            end else begin
               state_s = S_DONE;
            end
         end
         default: begin
            idx_s   = {IDX_W{1'b0}};
            state_s = S_READ;
         end
      endcase
   end

   assign boot_done = boot_done_r;
   assign core_hold = core_hold_r;

   imem_port_mux u_imem_port_mux (
      .sel_core   (boot_done_r),
      .copy_valid (copy_valid_s),
      .copy_we    (1'b1),
      .copy_addr  (copy_addr_s),
      .copy_wdata (copy_wdata_s),
      .copy_ready (copy_ready_s),
      .core_valid (core_req_valid),
      .core_addr  (core_req_addr),
      .core_ready (core_req_ready),
      .imem_valid (imem_req_valid),
      .imem_we    (imem_req_we),
      .imem_addr  (imem_req_addr),
      .imem_wdata (imem_req_wdata),
      .imem_ready (imem_req_ready)
   );

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// -----------------------------------------------------------------------------
// tb_boot_loader_ctrl
// Two instances share all inputs: d0 (4 words at base 0) and d1 (1 word at
// base 0x8000_0000). A transaction-level model (next word to write, whether
// its write is being presented, whether boot is complete) predicts every
// output on each negative edge; a write scoreboard confirms each word is
// written exactly once per copy. Directed sequences add literal checks.
// -----------------------------------------------------------------------------
module tb_boot_loader_ctrl;

   localparam int          N0    = 4;
   localparam int          N1    = 1;
   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'h8000_0000;

   logic        clock;
   logic        reset;
   logic        imem_req_ready;
   logic        core_req_valid;
   logic [31:0] core_req_addr;
   logic        reboot_req;

   logic [31:0] ba0, bd_in0, a0, wd0;
   logic        v0, we0, crr0, ch0, bd0;
   logic [31:0] ba1, bd_in1, a1, wd1;
   logic        v1, we1, crr1, ch1, bd1;

   // Boot memory contents: word k holds 0x10 + k.
   assign bd_in0 = 32'h0000_0010 + ba0;
   assign bd_in1 = 32'h0000_0010 + ba1;

   boot_loader_ctrl #(.BOOT_WORDS(N0), .IMEM_BASE(BASE0)) dut (
      .clock(clock), .reset(reset), .bmem_addr(ba0), .bmem_data(bd_in0),
      .imem_req_valid(v0), .imem_req_we(we0), .imem_req_addr(a0),
      .imem_req_wdata(wd0), .imem_req_ready(imem_req_ready),
      .core_req_valid(core_req_valid), .core_req_addr(core_req_addr),
      .core_req_ready(crr0), .core_hold(ch0), .boot_done(bd0),
      .reboot_req(reboot_req)
   );

   boot_loader_ctrl #(.BOOT_WORDS(N1), .IMEM_BASE(BASE1)) dut1 (
      .clock(clock), .reset(reset), .bmem_addr(ba1), .bmem_data(bd_in1),
      .imem_req_valid(v1), .imem_req_we(we1), .imem_req_addr(a1),
      .imem_req_wdata(wd1), .imem_req_ready(imem_req_ready),
      .core_req_valid(core_req_valid), .core_req_addr(core_req_addr),
      .core_req_ready(crr1), .core_hold(ch1), .boot_done(bd1),
      .reboot_req(reboot_req)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   int          m_n    [2] = '{N0, N1};
   logic [31:0] m_base [2] = '{BASE0, BASE1};
   bit          m_done [2];
   bit          m_pend [2];
   int          m_w    [2];
   bit          m_live = 1'b0;
   int          wr_cnt [2][N0];
   int          acc    [2] = '{0, 0};

   task automatic restart(input int i);
      m_done[i] = 1'b0;
      m_pend[i] = 1'b0;
      m_w[i]    = 0;
      for (int k = 0; k < N0; k++) wr_cnt[i][k] = 0;
   endtask

   // Advance the model on each active edge using the inputs seen at that edge.
   always @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            restart(i);
         end else if (m_done[i]) begin
            if (reboot_req) restart(i);
         end else if (!m_pend[i]) begin
            m_pend[i] = 1'b1;
         end else if (imem_req_ready) begin
            m_w[i]++;
            m_pend[i] = 1'b0;
            if (m_w[i] == m_n[i]) begin
               m_done[i] = 1'b1;
               for (int k = 0; k < m_n[i]; k++)
                  chk($sformatf("sb_once_d%0d_w%0d", i, k), wr_cnt[i][k], 32'd1);
            end
         end
      end
      if (reset) m_live = 1'b1;
   end

   task automatic check_outputs(input int i, input logic v, input logic we,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] ba, input logic cr,
                                input logic ch, input logic bd);
      int k;
      if (v === 1'b1 && we === 1'b1 && imem_req_ready === 1'b1) begin
         k = int'((a - m_base[i]) >> 2);
         if (k >= 0 && k < m_n[i]) begin
            wr_cnt[i][k]++;
            acc[i]++;
         end else begin
            chk($sformatf("d%0d_wr_range", i), a, m_base[i]);
         end
      end
      chk($sformatf("d%0d_hold_vs_done", i), {31'd0, ch}, {31'd0, ~bd});
      if (m_done[i]) begin
         chk($sformatf("d%0d_done", i), {31'd0, bd}, 32'd1);
         chk($sformatf("d%0d_bmem_addr_done", i), ba, 32'd0);
         chk($sformatf("d%0d_pt_valid", i), {31'd0, v}, {31'd0, core_req_valid});
         chk($sformatf("d%0d_pt_we", i), {31'd0, we}, 32'd0);
         chk($sformatf("d%0d_pt_addr", i), a, core_req_addr);
         chk($sformatf("d%0d_pt_wdata", i), wd, 32'd0);
         chk($sformatf("d%0d_pt_ready", i), {31'd0, cr}, {31'd0, imem_req_ready});
      end else begin
         chk($sformatf("d%0d_done", i), {31'd0, bd}, 32'd0);
         chk($sformatf("d%0d_core_ready_boot", i), {31'd0, cr}, 32'd0);
         if (m_pend[i]) begin
            chk($sformatf("d%0d_wr_valid", i), {31'd0, v}, 32'd1);
            chk($sformatf("d%0d_wr_we", i), {31'd0, we}, 32'd1);
            chk($sformatf("d%0d_wr_addr", i), a, m_base[i] + 32'(4 * m_w[i]));
            chk($sformatf("d%0d_wr_data", i), wd, 32'h10 + 32'(m_w[i]));
         end else begin
            chk($sformatf("d%0d_rd_valid", i), {31'd0, v}, 32'd0);
            chk($sformatf("d%0d_rd_bmem_addr", i), ba, 32'(m_w[i]));
         end
      end
   endtask

   // Compare both DUTs against the model mid-cycle.
   always @(negedge clock) begin
      if (m_live) begin
         check_outputs(0, v0, we0, a0, wd0, ba0, crr0, ch0, bd0);
         check_outputs(1, v1, we1, a1, wd1, ba1, crr1, ch1, bd1);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic at_mid();
      @(negedge clock);
   endtask

   int base_acc;

   initial begin
      reset          = 1'b1;
      imem_req_ready = 1'b1;
      core_req_valid = 1'b0;
      core_req_addr  = 32'h0;
      reboot_req     = 1'b0;

      // 1 + 6: plain copy with ready high
      next_cycle();
      next_cycle();
      reset = 1'b0;
      at_mid();                                   // cycle 1
      chk("t1_rst_hold", {31'd0, ch0}, 32'd1);
      chk("t1_rst_done", {31'd0, bd0}, 32'd0);
      chk("t1_rst_valid", {31'd0, v0}, 32'd0);
      chk("t1_rst_core_ready", {31'd0, crr0}, 32'd0);
      chk("t1_rst_bmem_addr", ba0, 32'd0);
      base_acc = acc[0];
      next_cycle(); at_mid();                     // cycle 2
      chk("t1_c2_valid", {31'd0, v0}, 32'd1);
      chk("t1_c2_addr", a0, 32'h0);
      chk("t1_c2_wdata", wd0, 32'h10);
      chk("t6_c2_addr", a1, 32'h8000_0000);
      chk("t6_c2_wdata", wd1, 32'h10);
      next_cycle(); at_mid();                     // cycle 3
      chk("t6_c3_done", {31'd0, bd1}, 32'd1);
      chk("t6_c3_bmem_addr", ba1, 32'd0);
      repeat (5) next_cycle();
      at_mid();                                   // cycle 8
      chk("t1_c8_addr", a0, 32'hC);
      chk("t1_c8_wdata", wd0, 32'h13);
      next_cycle(); at_mid();                     // cycle 9
      chk("t1_c9_done", {31'd0, bd0}, 32'd1);
      chk("t1_c9_hold", {31'd0, ch0}, 32'd0);
      chk("t1_write_count", 32'(acc[0] - base_acc), 32'd4);

      // 2: backpressure on word 1, core requesting during the copy
      reset          = 1'b1;
      core_req_valid = 1'b1;
      core_req_addr  = 32'h40;
      next_cycle();
      reset = 1'b0;                               // cycle 1
      base_acc = acc[0];
      next_cycle(); next_cycle(); at_mid();       // cycle 3
      chk("t3_boot_no_fwd_valid", {31'd0, v0}, 32'd0);
      chk("t3_boot_core_ready", {31'd0, crr0}, 32'd0);
      next_cycle();                               // cycle 4
      imem_req_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         at_mid();
         chk("t2_stall_valid", {31'd0, v0}, 32'd1);
         chk("t2_stall_addr", a0, 32'h4);
         chk("t2_stall_wdata", wd0, 32'h11);
         chk("t2_stall_core_ready", {31'd0, crr0}, 32'd0);
         next_cycle();
      end
      imem_req_ready = 1'b1;                      // cycle 7
      repeat (4) next_cycle();
      at_mid();                                   // cycle 11
      chk("t2_c11_not_done", {31'd0, bd0}, 32'd0);
      next_cycle(); at_mid();                     // cycle 12
      chk("t2_c12_done", {31'd0, bd0}, 32'd1);
      chk("t2_write_count", 32'(acc[0] - base_acc), 32'd4);

      // 3: pass-through with ready pattern 1,0,1
      chk("t3_pt_valid", {31'd0, v0}, 32'd1);
      chk("t3_pt_we", {31'd0, we0}, 32'd0);
      chk("t3_pt_addr", a0, 32'h40);
      chk("t3_pt_ready1", {31'd0, crr0}, 32'd1);
      next_cycle();
      imem_req_ready = 1'b0;
      at_mid();
      chk("t3_pt_ready0", {31'd0, crr0}, 32'd0);
      next_cycle();
      imem_req_ready = 1'b1;
      at_mid();
      chk("t3_pt_ready1b", {31'd0, crr0}, 32'd1);
      next_cycle();
      core_req_valid = 1'b0;
      at_mid();
      chk("t3_pt_idle", {31'd0, v0}, 32'd0);

      // 4: reboot from done, plus an ignored pulse mid-copy
      next_cycle();
      reboot_req     = 1'b1;
      core_req_valid = 1'b1;
      core_req_addr  = 32'h44;
      at_mid();
      chk("t4_reboot_cycle_pt_addr", a0, 32'h44);
      chk("t4_reboot_cycle_done", {31'd0, bd0}, 32'd1);
      next_cycle();                               // new cycle 1
      reboot_req = 1'b0;
      at_mid();
      chk("t4_hold", {31'd0, ch0}, 32'd1);
      chk("t4_not_done", {31'd0, bd0}, 32'd0);
      chk("t4_no_fwd", {31'd0, v0}, 32'd0);
      base_acc = acc[0];
      next_cycle(); at_mid();                     // cycle 2
      chk("t4_c2_addr", a0, 32'h0);
      chk("t4_c2_wdata", wd0, 32'h10);
      next_cycle();                               // cycle 3
      reboot_req = 1'b1;
      next_cycle();                               // cycle 4
      reboot_req = 1'b0;
      at_mid();
      chk("t4_c4_addr", a0, 32'h4);
      repeat (5) next_cycle();
      at_mid();                                   // cycle 9
      chk("t4_c9_done", {31'd0, bd0}, 32'd1);
      chk("t4_write_count", 32'(acc[0] - base_acc), 32'd4);

      // 5: reset while word 2 is stalled
      core_req_valid = 1'b0;
      reset          = 1'b1;
      next_cycle();
      reset = 1'b0;                               // cycle 1
      repeat (5) next_cycle();                    // cycle 6: writing word 2
      imem_req_ready = 1'b0;
      reset          = 1'b1;
      at_mid();
      chk("t5_pre_addr", a0, 32'h8);
      chk("t5_pre_valid", {31'd0, v0}, 32'd1);
      next_cycle();
      reset = 1'b0;
      at_mid();
      chk("t5_post_valid", {31'd0, v0}, 32'd0);
      chk("t5_post_bmem_addr", ba0, 32'd0);
      base_acc = acc[0];
      imem_req_ready = 1'b1;
      next_cycle(); at_mid();                     // cycle 2
      chk("t5_c2_addr", a0, 32'h0);
      repeat (7) next_cycle();
      at_mid();                                   // cycle 9
      chk("t5_c9_done", {31'd0, bd0}, 32'd1);
      chk("t5_write_count", 32'(acc[0] - base_acc), 32'd4);

      next_cycle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
